bcd_to_binary_converter: RTL and testbench

- Sequential decimal-to-binary decoder; the inverse of the binary-to-decimal converter feeding the LCD.
- Takes a packed BCD number, for example decimal digits entered on the 4x4 keypad.
- Produces the unsigned binary value using iterative multiply-by-10-and-add, one digit per clock.
- Start/busy/done handshake; flags for overflow and non-decimal digits.

---
 rtl/bcd_to_binary_converter.sv | 102 ++++++++++
 tb/tb_bcd_to_binary_converter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to unsigned binary decoder: one digit per clock,
// MSD first, with saturation on overflow and a flag for non-decimal digits.
module bcd_to_binary_converter #(
  parameter int DIGITS = 5,
  parameter int OUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      value,
  output logic                  overflow,
  output logic                  invalid
);

  localparam int ACC_W = OUT_W + 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [ACC_W-1:0] MAX_VAL = {4'b0000, {OUT_W{1'b1}}};
  // Clamp just above the representable range so later *10 steps cannot wrap
  localparam logic [ACC_W-1:0] CLAMP   = {3'b000, 1'b1, {OUT_W{1'b0}}};

  typedef enum logic {IDLE, CONV} state_t;

  state_t                    state;
  logic [DIGITS-1:0][3:0]    shadow;
  logic [ACC_W-1:0]          acc;
  logic [IDX_W-1:0]          idx;
  logic                      inv_q, ovf_q;

  logic [3:0]                digit;
  logic [ACC_W-1:0]          acc_sum;
  logic                      step_inv, step_ovf, fin_inv, fin_ovf;

  always_comb begin
    digit    = shadow[idx];
    acc_sum  = (acc << 3) + (acc << 1) + ACC_W'(digit);
    step_inv = (digit > 4'd9);
    step_ovf = (acc_sum > MAX_VAL);
    fin_inv  = inv_q | step_inv;
    fin_ovf  = ovf_q | step_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      acc      <= '0;
      idx      <= '0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      value    <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= bcd;
            acc    <= '0;
            idx    <= IDX_W'(DIGITS - 1);
            inv_q  <= 1'b0;
            ovf_q  <= 1'b0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          acc   <= step_ovf ? CLAMP : acc_sum;
          inv_q <= fin_inv;
          ovf_q <= fin_ovf;
          idx   <= idx - 1'b1;
          if (idx == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // A bad digit makes the number meaningless, so it outranks overflow
            if (fin_inv) begin
              value    <= '0;
              invalid  <= 1'b1;
              overflow <= 1'b0;
            end else if (fin_ovf) begin
              value    <= '1;
              invalid  <= 1'b0;
              overflow <= 1'b1;
            end else begin
              value    <= acc_sum[OUT_W-1:0];
              invalid  <= 1'b0;
              overflow <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Self-checking bench for bcd_to_binary_converter: directed boundary cases,
// handshake scenarios and randomized BCD against a decimal reference model.
module tb_bcd_to_binary_converter;
  localparam int DIGITS = 5;
  localparam int OUT_W  = 16;
  localparam int LAT    = DIGITS + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd = '0;
  logic                busy, done, overflow, invalid;
  logic [OUT_W-1:0]    value;

  int tests = 0;
  int fails = 0;

  bcd_to_binary_converter #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd(bcd),
    .busy(busy), .done(done), .value(value),
    .overflow(overflow), .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Reference: read the digits as a decimal number with plain arithmetic
  function automatic void model(input logic [4*DIGITS-1:0] b,
                                output logic [OUT_W-1:0] v,
                                output logic o, output logic i);
    longint n = 0;
    logic   bad = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      int d = int'(b[4*k +: 4]);
      if (d > 9) bad = 1'b1;
      n = n * 10 + d;
    end
    if (bad) begin v = '0; o = 1'b0; i = 1'b1; end
    else if (n > longint'((1 << OUT_W) - 1)) begin v = '1; o = 1'b1; i = 1'b0; end
    else begin v = OUT_W'(n); o = 1'b0; i = 1'b0; end
  endfunction

  // Drive one start pulse and wait (bounded) for done; returns observations
  task automatic run_conv(input logic [4*DIGITS-1:0] b, output int lat,
                          output int busy_bad, output logic [OUT_W-1:0] v,
                          output logic o, output logic i);
    @(negedge clk);
    bcd = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_bad = 0;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) busy_bad++;
    v = value; o = overflow; i = invalid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, value, overflow, invalid} !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b value=%h ovf=%b inv=%b, want all 0",
               busy, done, value, overflow, invalid);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [4*DIGITS-1:0] vec [7] = '{20'h12345, 20'h00000, 20'h65535, 20'h65536,
                                     20'h99999, 20'h12A45, 20'hF9999};
    logic [OUT_W-1:0]    ev   [7] = '{16'h3039, 16'h0000, 16'hFFFF, 16'hFFFF,
                                     16'hFFFF, 16'h0000, 16'h0000};
    logic [1:0]          ef   [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01};
    int lat, bb; logic [OUT_W-1:0] v; logic o, i;
    for (int k = 0; k < 7; k++) begin
      run_conv(vec[k], lat, bb, v, o, i);
      tests++;
      if (lat !== LAT || bb !== 0) begin
        fails++;
        $display("FAIL directed_timing %h: done at %0d busy_err=%0d, want %0d/0",
                 vec[k], lat, bb, LAT);
      end
      tests++;
      if (v !== ev[k] || {o, i} !== ef[k]) begin
        fails++;
        $display("FAIL directed_value %h: got %h ovf=%b inv=%b, want %h ovf=%b inv=%b",
                 vec[k], v, o, i, ev[k], ef[k][1], ef[k][0]);
      end
    end
  endtask

  task automatic test_random();
    int lat, bb; logic [OUT_W-1:0] v, xv; logic o, i, xo, xi;
    logic [4*DIGITS-1:0] b;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < DIGITS; k++)
        b[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      if (n % 3 == 0) b[4*DIGITS-1 -: 4] = 4'd6;
      model(b, xv, xo, xi);
      run_conv(b, lat, bb, v, o, i);
      tests++;
      if (lat !== LAT || bb !== 0 || v !== xv || o !== xo || i !== xi) begin
        fails++;
        $display("FAIL random %h: got %h ovf=%b inv=%b lat=%0d busy_err=%0d, want %h ovf=%b inv=%b lat=%0d",
                 b, v, o, i, lat, bb, xv, xo, xi, LAT);
      end
    end
  endtask

  task automatic test_start_held();
    int last = -1, cnt = 0, bad_gap = 0, bad_val = 0;
    @(negedge clk);
    bcd = 20'h00042; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        if (value !== 16'h002A || overflow || invalid) bad_val++;
        if (last >= 0 && c - last != LAT) bad_gap++;
        last = c; cnt++;
      end
    end
    start = 1'b0;
    for (int c = 0; c < 10 && (busy || done); c++) @(negedge clk);
    tests++;
    if (cnt < 4 || bad_gap != 0) begin
      fails++;
      $display("FAIL start_held_rate: %0d dones, %0d bad gaps, want >=4 dones every %0d",
               cnt, bad_gap, LAT);
    end
    tests++;
    if (bad_val != 0) begin
      fails++;
      $display("FAIL start_held_value: %0d bad results, want 0 (002A)", bad_val);
    end
  endtask

  task automatic test_ignore_busy();
    int lat = 0; logic post_busy;
    @(negedge clk);
    bcd = 20'h12345; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bcd = 20'h98765;
    @(negedge clk);
    bcd = 20'h00007; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bcd = 20'($urandom);
    lat = 3;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    tests++;
    if (lat !== LAT || value !== 16'h3039 || overflow || invalid) begin
      fails++;
      $display("FAIL ignore_busy: value=%h at %0d, want 3039 at %0d", value, lat, LAT);
    end
    @(negedge clk);
    post_busy = busy;
    tests++;
    if (post_busy !== 1'b0) begin
      fails++;
      $display("FAIL start_not_queued: busy=%b after done, want 0", post_busy);
    end
  endtask

  task automatic test_reset_mid();
    int saw_done = 0, lat, bb; logic [OUT_W-1:0] v; logic o, i;
    @(negedge clk);
    bcd = 20'h12345; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    tests++;
    if (saw_done != 0 || busy !== 1'b0 || value !== '0) begin
      fails++;
      $display("FAIL reset_mid: dones=%0d busy=%b value=%h, want 0/0/0000",
               saw_done, busy, value);
    end
    run_conv(20'h00100, lat, bb, v, o, i);
    tests++;
    if (lat !== LAT || bb !== 0 || v !== 16'h0064 || o || i) begin
      fails++;
      $display("FAIL after_reset: value=%h lat=%0d, want 0064 lat=%0d", v, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_ignore_busy();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
